dmemory_pipe: RTL and testbench

Parametrised data memory for the CPU datapath with a built-in memory-mapped I/O register window, a valid/ready request interface, configurable read latency and an optional clear-on-reset sweep. Sits between the CPU load/store stage and the I/O peripherals. The MMIO register outputs drive peripherals directly. A second, read-only debug port lets the display/IO logic inspect any address.

---
 rtl/dmemory_pipe.sv | 166 ++++++++++++++++
 tb/tb_dmemory_pipe.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmemory_pipe.sv
// Data memory with an MMIO register window, valid/ready request port, 1- or 2-cycle
// read latency, a post-reset clear sweep and a registered read-only debug port.
module dmemory_pipe #(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 8,
  parameter int MMIO_BASE      = 'hF0,
  parameter int MMIO_COUNT     = 4,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         write_en,
  input  logic [ADDR_W-1:0]            addr_in,
  input  logic [DATA_W-1:0]            data_in,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            data_out,
  output logic [MMIO_COUNT*DATA_W-1:0] mmio_out,
  input  logic [ADDR_W-1:0]            memory_mapped_io_addr_in,
  output logic [DATA_W-1:0]            memory_mapped_io_data_out,
  output logic                         busy
);
  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0]   MMIO_LO   = (ADDR_W+1)'(MMIO_BASE);
  localparam logic [ADDR_W:0]   MMIO_HI   = (ADDR_W+1)'(MMIO_BASE + MMIO_COUNT);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              clr_we;

  logic [DATA_W-1:0] ram_q  [DEPTH];
  logic [DATA_W-1:0] mmio_q [MMIO_COUNT];

  function automatic logic in_window(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= MMIO_LO) && ({1'b0, a} < MMIO_HI);
  endfunction

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy      = 1'b0;
    req_ready = 1'b0;
    clr_we    = 1'b0;
    if (reset) begin
      busy = (CLEAR_ON_RESET != 0);
    end else begin
      case (state_q)
        ST_CLEAR: begin
          busy      = 1'b1;
          clr_we    = !in_window(clr_cnt_q);
          clr_cnt_d = clr_cnt_q + 1'b1;
          if (clr_cnt_q == LAST_ADDR) state_d = ST_RUN;
        end
        default: req_ready = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  logic acc, wr_acc, rd_acc, req_mmio;
  assign acc      = req_valid && req_ready;
  assign wr_acc   = acc && write_en;
  assign rd_acc   = acc && !write_en;
  assign req_mmio = in_window(addr_in);

  logic [DATA_W-1:0] req_mmio_val, dbg_mmio_val;
  always_comb begin
    req_mmio_val = '0;
    dbg_mmio_val = '0;
    for (int k = 0; k < MMIO_COUNT; k++) begin
      if (addr_in == ADDR_W'(MMIO_BASE + k)) req_mmio_val = mmio_q[k];
      if (memory_mapped_io_addr_in == ADDR_W'(MMIO_BASE + k)) dbg_mmio_val = mmio_q[k];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < MMIO_COUNT; k++) begin
      if (reset) mmio_q[k] <= '0;
      else if (wr_acc && addr_in == ADDR_W'(MMIO_BASE + k)) mmio_q[k] <= data_in;
    end
  end

  generate
    for (genvar gi = 0; gi < MMIO_COUNT; gi++) begin : g_mmio_out
      assign mmio_out[gi*DATA_W +: DATA_W] = mmio_q[gi];
    end
  endgenerate

  // Single write port shared by the clear sweep and accepted CPU writes.
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  assign ram_we    = clr_we || (wr_acc && !req_mmio);
  assign ram_waddr = clr_we ? clr_cnt_q : addr_in;
  assign ram_wdata = clr_we ? '0 : data_in;

  always_ff @(posedge clk) begin
    if (ram_we) ram_q[ram_waddr] <= ram_wdata;
  end

  logic              rd1_valid_q, rd1_mmio_q;
  logic [DATA_W-1:0] rd1_ram_q, rd1_mmio_val_q, rd1_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd1_valid_q    <= 1'b0;
      rd1_mmio_q     <= 1'b0;
      rd1_ram_q      <= '0;
      rd1_mmio_val_q <= '0;
    end else begin
      rd1_valid_q <= rd_acc;
      if (rd_acc) begin
        rd1_ram_q      <= ram_q[addr_in];
        rd1_mmio_q     <= req_mmio;
        rd1_mmio_val_q <= req_mmio_val;
      end
    end
  end

  // Stage-1 registers only load on a read, so this mux already holds between responses.
  assign rd1_data = rd1_mmio_q ? rd1_mmio_val_q : rd1_ram_q;

  generate
    if (READ_LATENCY == 1) begin : g_lat1
      assign rsp_valid = rd1_valid_q;
      assign data_out  = rd1_data;
    end else begin : g_lat2
      logic              rsp_q;
      logic [DATA_W-1:0] dout_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          rsp_q  <= 1'b0;
          dout_q <= '0;
        end else begin
          rsp_q <= rd1_valid_q;
          if (rd1_valid_q) dout_q <= rd1_data;
        end
      end
      assign rsp_valid = rsp_q;
      assign data_out  = dout_q;
    end
  endgenerate

  logic [DATA_W-1:0] dbg_q;
  always_ff @(posedge clk) begin
    if (reset || busy) dbg_q <= '0;
    else if (in_window(memory_mapped_io_addr_in)) dbg_q <= dbg_mmio_val;
    else dbg_q <= ram_q[memory_mapped_io_addr_in];
  end
  assign memory_mapped_io_data_out = dbg_q;

endmodule

// File: tb/tb_dmemory_pipe.sv
// Bench for dmemory_pipe: two instances (read latency 1 and 2) share one stimulus stream
// and are compared against a flat-array memory model with a response queue per latency.
module tb_dmemory_pipe;
  logic        clk = 1'b0;
  logic        reset = 1'b0, req_valid = 1'b0, write_en = 1'b0;
  logic [7:0]  addr_in = '0, data_in = '0, dbg_addr = '0;
  logic        ready1, ready2, rv1, rv2, busy1, busy2;
  logic [7:0]  dout1, dout2, dbg1, dbg2;
  logic [31:0] mmio1, mmio2;

  always #5 clk = ~clk;

  dmemory_pipe #(.READ_LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready1),
    .write_en(write_en), .addr_in(addr_in), .data_in(data_in),
    .rsp_valid(rv1), .data_out(dout1), .mmio_out(mmio1),
    .memory_mapped_io_addr_in(dbg_addr), .memory_mapped_io_data_out(dbg1), .busy(busy1));

  dmemory_pipe #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(ready2),
    .write_en(write_en), .addr_in(addr_in), .data_in(data_in),
    .rsp_valid(rv2), .data_out(dout2), .mmio_out(mmio2),
    .memory_mapped_io_addr_in(dbg_addr), .memory_mapped_io_data_out(dbg2), .busy(busy2));

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: whole address space as one array (MMIO words included).
  typedef struct { int due; logic [7:0] d; } rsp_t;
  logic [7:0] mem [256];
  rsp_t       q1[$], q2[$];
  int         busy_left = 0;
  logic [7:0] last1 = '0, last2 = '0, exp_dbg = '0;
  logic       exp_rv1, exp_rv2, exp_busy, exp_ready;
  logic       obs_busy1, obs_busy2, obs_ready1, obs_ready2;

  function automatic logic [31:0] mmio_exp();
    return {mem[8'hF3], mem[8'hF2], mem[8'hF1], mem[8'hF0]};
  endfunction

  // Drive one cycle of inputs, capture combinational status before the edge,
  // then advance the model across the edge.
  task automatic tick(input logic r, input logic v, input logic we,
                      input logic [7:0] a, input logic [7:0] d, input logic [7:0] dbg);
    logic acc;
    rsp_t e;
    reset = r; req_valid = v; write_en = we; addr_in = a; data_in = d; dbg_addr = dbg;
    #2;
    obs_busy1 = busy1; obs_busy2 = busy2; obs_ready1 = ready1; obs_ready2 = ready2;
    exp_busy  = r ? 1'b1 : (busy_left > 0);
    exp_ready = !r && (busy_left == 0);
    acc = v && exp_ready;
    @(posedge clk);
    cyc++;
    if (r) begin
      exp_dbg = '0;
      foreach (mem[i]) mem[i] = '0;
      q1.delete(); q2.delete();
      last1 = '0; last2 = '0;
      busy_left = 256;
    end else begin
      exp_dbg = (busy_left > 0) ? 8'h00 : mem[dbg];
      if (busy_left > 0) busy_left--;
      if (acc && we) begin
        mem[a] = d;
        $display("cycle %0d: write addr=%02h data=%02h", cyc, a, d);
      end else if (acc) begin
        e.d = mem[a];
        e.due = cyc;     q1.push_back(e);
        e.due = cyc + 1; q2.push_back(e);
        $display("cycle %0d: read addr=%02h model=%02h", cyc, a, e.d);
      end
    end
    exp_rv1 = 1'b0;
    if (q1.size() > 0 && q1[0].due == cyc) begin exp_rv1 = 1'b1; last1 = q1[0].d; void'(q1.pop_front()); end
    exp_rv2 = 1'b0;
    if (q2.size() > 0 && q2[0].due == cyc) begin exp_rv2 = 1'b1; last2 = q2[0].d; void'(q2.pop_front()); end
    #1;
  endtask

  task automatic test_reset();
    int n = 0;
    tick(1, 0, 0, 8'h00, 8'h00, 8'h00);
    checks++; if (obs_busy1 !== 1'b1 || obs_busy2 !== 1'b1 || obs_ready1 !== 1'b0 || obs_ready2 !== 1'b0) begin errors++;
      $display("FAIL reset_status: busy=%b/%b ready=%b/%b, expected busy=1 ready=0", obs_busy1, obs_busy2, obs_ready1, obs_ready2); end
    checks++; if (rv1 !== 1'b0 || rv2 !== 1'b0 || dout1 !== 8'h00 || dout2 !== 8'h00) begin errors++;
      $display("FAIL reset_rsp: rv=%b/%b dout=%h/%h, expected 0", rv1, rv2, dout1, dout2); end
    checks++; if (mmio1 !== 32'h0 || mmio2 !== 32'h0 || dbg1 !== 8'h00 || dbg2 !== 8'h00) begin errors++;
      $display("FAIL reset_regs: mmio=%h/%h dbg=%h/%h, expected 0", mmio1, mmio2, dbg1, dbg2); end
    for (int i = 0; i < 300; i++) begin
      tick(0, 0, 0, 8'h00, 8'h00, 8'h00);
      if (!obs_busy1) break;
      if (obs_ready1 !== 1'b0) break;
      n++;
    end
    checks++; if (n !== 256 || obs_busy2 !== 1'b0 || obs_ready1 !== 1'b1 || obs_ready2 !== 1'b1) begin errors++;
      $display("FAIL sweep_length: busy cycles=%0d ready=%b/%b, expected 256 and ready=1", n, obs_ready1, obs_ready2); end
    tick(0, 1, 0, 8'h37, 8'h00, 8'h00);
    checks++; if (rv1 !== 1'b1 || dout1 !== 8'h00) begin errors++;
      $display("FAIL clear_read1: rv=%b data=%h, expected 1/00", rv1, dout1); end
    tick(0, 0, 0, 8'h00, 8'h00, 8'h00);
    checks++; if (rv2 !== 1'b1 || dout2 !== 8'h00 || rv1 !== 1'b0) begin errors++;
      $display("FAIL clear_read2: rv2=%b data=%h rv1=%b, expected 1/00/0", rv2, dout2, rv1); end
  endtask

  task automatic test_raw();
    tick(0, 1, 1, 8'h10, 8'h5A, 8'h00);
    tick(0, 1, 0, 8'h10, 8'h00, 8'h00);
    checks++; if (rv1 !== 1'b1 || dout1 !== 8'h5A) begin errors++;
      $display("FAIL raw_lat1: rv=%b data=%h, expected 1/5a", rv1, dout1); end
    tick(0, 0, 0, 8'h00, 8'h00, 8'h00);
    checks++; if (rv1 !== 1'b0 || dout1 !== 8'h5A || rv2 !== 1'b1 || dout2 !== 8'h5A) begin errors++;
      $display("FAIL raw_hold: rv1=%b d1=%h rv2=%b d2=%h, expected 0/5a 1/5a", rv1, dout1, rv2, dout2); end
    tick(0, 0, 0, 8'h00, 8'h00, 8'h00);
    checks++; if (rv2 !== 1'b0 || dout2 !== 8'h5A) begin errors++;
      $display("FAIL raw_hold2: rv2=%b d2=%h, expected 0/5a", rv2, dout2); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pre [3];
    logic [7:0] e1, e2;
    pre[0] = 8'hA1; pre[1] = 8'hA2; pre[2] = 8'hA3;
    for (int k = 0; k < 3; k++) tick(0, 1, 1, 8'(k + 1), pre[k], 8'h00);
    for (int k = 0; k < 5; k++) begin
      tick(0, k < 3, 0, 8'(k + 1), 8'h00, 8'h00);
      e1 = pre[(k < 3) ? k : 2];
      e2 = pre[(k >= 1 && k <= 3) ? k - 1 : 2];
      checks++; if (rv1 !== (k < 3) || dout1 !== e1) begin errors++;
        $display("FAIL b2b_lat1 step %0d: rv=%b data=%h, expected %b/%h", k, rv1, dout1, k < 3, e1); end
      checks++; if (rv2 !== (k >= 1 && k <= 3) || (k >= 1 && dout2 !== e2)) begin errors++;
        $display("FAIL b2b_lat2 step %0d: rv=%b data=%h, expected %b/%h", k, rv2, dout2, (k >= 1 && k <= 3), e2); end
    end
  endtask

  task automatic test_mmio();
    tick(0, 1, 1, 8'hF2, 8'hC3, 8'hF2);
    checks++; if (mmio1 !== 32'h00C3_0000 || mmio2 !== 32'h00C3_0000 || dbg1 !== 8'h00) begin errors++;
      $display("FAIL mmio_write: mmio=%h/%h dbg=%h, expected 00c30000 and dbg 00", mmio1, mmio2, dbg1); end
    tick(0, 1, 0, 8'hF2, 8'h00, 8'hF2);
    checks++; if (rv1 !== 1'b1 || dout1 !== 8'hC3 || dbg1 !== 8'hC3 || dbg2 !== 8'hC3) begin errors++;
      $display("FAIL mmio_read: rv=%b data=%h dbg=%h/%h, expected 1/c3 c3/c3", rv1, dout1, dbg1, dbg2); end
    tick(0, 0, 0, 8'h00, 8'h00, 8'hF2);
    checks++; if (rv2 !== 1'b1 || dout2 !== 8'hC3) begin errors++;
      $display("FAIL mmio_read2: rv=%b data=%h, expected 1/c3", rv2, dout2); end
  endtask

  task automatic test_reset_mid_sweep();
    int n = 0;
    tick(0, 1, 1, 8'hF0, 8'h11, 8'h00);
    tick(0, 1, 1, 8'hC0, 8'h99, 8'h00);
    tick(0, 1, 1, 8'h37, 8'h77, 8'h00);
    tick(1, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 100; i++) tick(0, 0, 0, 8'h00, 8'h00, 8'hC0);
    checks++; if (obs_busy1 !== 1'b1 || obs_busy2 !== 1'b1 || dbg1 !== 8'h00) begin errors++;
      $display("FAIL mid_sweep_busy: busy=%b/%b dbg=%h, expected 1/1 00", obs_busy1, obs_busy2, dbg1); end
    tick(1, 0, 0, 8'h00, 8'h00, 8'h00);
    checks++; if (mmio1 !== 32'h0 || mmio2 !== 32'h0) begin errors++;
      $display("FAIL mid_sweep_mmio: mmio=%h/%h, expected 0", mmio1, mmio2); end
    for (int i = 0; i < 300; i++) begin
      tick(0, 0, 0, 8'h00, 8'h00, 8'h00);
      if (!obs_busy1) break;
      n++;
    end
    checks++; if (n !== 256) begin errors++;
      $display("FAIL restart_length: busy cycles=%0d, expected 256", n); end
    tick(0, 1, 0, 8'hC0, 8'h00, 8'h00);
    checks++; if (rv1 !== 1'b1 || dout1 !== 8'h00) begin errors++;
      $display("FAIL restart_clear_c0: rv=%b data=%h, expected 1/00", rv1, dout1); end
    tick(0, 1, 0, 8'hF0, 8'h00, 8'h00);
    checks++; if (rv1 !== 1'b1 || dout1 !== 8'h00) begin errors++;
      $display("FAIL restart_mmio_f0: rv=%b data=%h, expected 1/00", rv1, dout1); end
  endtask

  task automatic test_busy_drop();
    int n = 0;
    tick(1, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 300; i++) begin
      tick(0, 1, 1, 8'h20, 8'hFF, 8'h20);
      if (!obs_busy1) break;
      n++;
      if (obs_ready1 !== 1'b0) break;
    end
    checks++; if (n !== 256) begin errors++;
      $display("FAIL busy_drop_length: busy cycles=%0d, expected 256", n); end
    tick(0, 1, 0, 8'h20, 8'h00, 8'h20);
    checks++; if (rv1 !== 1'b1 || dout1 !== mem[8'h20] || dout1 !== 8'hFF) begin errors++;
      $display("FAIL busy_drop_first_run: rv=%b data=%h, expected 1/ff (write accepted once ready)", rv1, dout1); end
    tick(1, 0, 0, 8'h00, 8'h00, 8'h00);
    for (int i = 0; i < 20; i++) tick(0, 1, 1, 8'h20, 8'hFF, 8'h20);
    for (int i = 0; i < 300 && obs_busy1; i++) tick(0, 0, 0, 8'h00, 8'h00, 8'h00);
    tick(0, 1, 0, 8'h20, 8'h00, 8'h00);
    checks++; if (rv1 !== 1'b1 || dout1 !== 8'h00) begin errors++;
      $display("FAIL busy_drop_read: rv=%b data=%h, expected 1/00", rv1, dout1); end
  endtask

  task automatic test_random();
    logic [7:0] a;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 2))
        0: a = 8'hF0 + 8'($urandom_range(0, 3));
        1: a = 8'($urandom_range(0, 7));
        default: a = 8'($urandom_range(0, 255));
      endcase
      tick(0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a, 8'($urandom), 8'($urandom_range(0, 255)));
      checks++; if (rv1 !== exp_rv1 || dout1 !== last1) begin errors++;
        $display("FAIL rand_lat1 cycle %0d: rv=%b data=%h, expected %b/%h", cyc, rv1, dout1, exp_rv1, last1); end
      checks++; if (rv2 !== exp_rv2 || dout2 !== last2) begin errors++;
        $display("FAIL rand_lat2 cycle %0d: rv=%b data=%h, expected %b/%h", cyc, rv2, dout2, exp_rv2, last2); end
      checks++; if (mmio1 !== mmio_exp() || mmio2 !== mmio_exp()) begin errors++;
        $display("FAIL rand_mmio cycle %0d: mmio=%h/%h, expected %h", cyc, mmio1, mmio2, mmio_exp()); end
      checks++; if (dbg1 !== exp_dbg || dbg2 !== exp_dbg) begin errors++;
        $display("FAIL rand_dbg cycle %0d: dbg=%h/%h, expected %h", cyc, dbg1, dbg2, exp_dbg); end
      checks++; if (obs_ready1 !== exp_ready || obs_busy1 !== exp_busy) begin errors++;
        $display("FAIL rand_status cycle %0d: ready=%b busy=%b, expected %b/%b", cyc, obs_ready1, obs_busy1, exp_ready, exp_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_back_to_back();
    test_mmio();
    test_reset_mid_sweep();
    test_busy_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
